// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch sequencer with an IDLE/RUN/DONE
// handshake. Optional executed-cycle counter enabled by defining CYCLE_CNT_EN;
// without it CycleCount is tied to zero.
module fetch_pc_unit #(
  parameter int PCW = 10,
  parameter int W   = 8,
  parameter int CW  = 16
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic           Start,
  input  logic           Stall,
  input  logic           BranchEn,
  input  logic           BranchRel,
  input  logic [W-1:0]   BranchReg,
  input  logic           HaltInstr,
  output logic [PCW-1:0] ProgCounter,
  output logic           FetchValid,
  output logic           Done,
  output logic [CW-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [PCW-1:0] next_pc;
  logic [PCW-1:0] rel_offset;
  logic [PCW-1:0] abs_target;

  // Branch register as a signed PC offset and as a zero-extended target;
  // both are fitted to PCW bits so the add wraps modulo 2**PCW.
  assign rel_offset = PCW'(signed'(BranchReg));
  assign abs_target = PCW'(BranchReg);

  // A fetch is live only while running and not frozen by a stall.
  assign FetchValid = (state == ST_RUN) && !Stall;

  // Next-state and next-PC selection: halt beats branch beats increment.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_state = state;
    next_pc    = ProgCounter;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          next_state = ST_RUN;
          next_pc    = '0;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (HaltInstr) begin
            next_state = ST_DONE;
          end else if (BranchEn) begin
            next_pc = BranchRel ? (ProgCounter + rel_offset) : abs_target;
          end else begin
            next_pc = ProgCounter + PCW'(1);
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_pc    = '0;
      end
    endcase
  end

  // State, PC and Done registers; synchronous reset has top priority.
  always_ff @(posedge Clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!ResetN) begin
      state       <= ST_IDLE;
      ProgCounter <= '0;
      Done        <= 1'b0;
    end else begin
      state       <= next_state;
      ProgCounter <= next_pc;
      Done        <= (next_state == ST_DONE);
    end
  end

`ifdef CYCLE_CNT_EN
  logic          count_step;
  logic          count_clear;
  logic [CW-1:0] cycle_q;

  assign count_step  = (state == ST_RUN) && !Stall;
  assign count_clear = (state != ST_RUN) && Start;

  // Saturating count of unstalled RUN cycles, cleared when a run starts.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      cycle_q <= '0;
    end else if (count_clear) begin
      cycle_q <= '0;
    end else if (count_step && (cycle_q != '1)) begin
      cycle_q <= cycle_q + CW'(1);
    end
  end

  assign CycleCount = cycle_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. Two instances share stimulus:
// PCW=10 (default) and PCW=4 (for a short wrap). A behavioural model tracks
// mode, PC and cycle count with plain integer arithmetic.
module tb_fetch_pc_unit;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int CC_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n, start, stall, br_en, br_rel, halt;
  logic [7:0]  br_reg;
  logic [9:0]  pc10;
  logic [3:0]  pc4;
  logic        fv10, fv4, done10, done4;
  logic [15:0] cc10, cc4;

  int n_checks = 0;
  int n_fail   = 0;
  int m_mode   = M_IDLE;
  int m_pc10   = 0;
  int m_pc4    = 0;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.PCW(10), .W(8), .CW(16)) dut10 (
    .Clk(clk), .ResetN(rst_n), .Start(start), .Stall(stall),
    .BranchEn(br_en), .BranchRel(br_rel), .BranchReg(br_reg),
    .HaltInstr(halt), .ProgCounter(pc10), .FetchValid(fv10),
    .Done(done10), .CycleCount(cc10)
  );

  fetch_pc_unit #(.PCW(4), .W(8), .CW(16)) dut4 (
    .Clk(clk), .ResetN(rst_n), .Start(start), .Stall(stall),
    .BranchEn(br_en), .BranchRel(br_rel), .BranchReg(br_reg),
    .HaltInstr(halt), .ProgCounter(pc4), .FetchValid(fv4),
    .Done(done4), .CycleCount(cc4)
  );

  // PC after an unstalled, non-halting RUN cycle, for a memory of n words.
  function automatic int model_pc(int pc, int n, bit ben, bit brel, logic [7:0] breg);
    int off;
    off = (breg >= 8'd128) ? int'(breg) - 256 : int'(breg);
    if (ben && brel) return ((pc + off) % n + n) % n;
    if (ben)         return int'(breg) % n;
    return (pc + 1) % n;
  endfunction

  function automatic int exp_cc();
`ifdef CYCLE_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge(bit rn, bit st, bit sl, bit ben, bit brel,
                            logic [7:0] breg, bit hl);
    if (!rn) begin
      m_mode = M_IDLE; m_pc10 = 0; m_pc4 = 0; m_cnt = 0;
    end else if (m_mode == M_RUN) begin
      if (!sl) begin
        if (m_cnt < CC_MAX) m_cnt++;
        if (hl) m_mode = M_DONE;
        else begin
          m_pc10 = model_pc(m_pc10, 1024, ben, brel, breg);
          m_pc4  = model_pc(m_pc4, 16, ben, brel, breg);
        end
      end
    end else if (st) begin
      m_mode = M_RUN; m_pc10 = 0; m_pc4 = 0; m_cnt = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then return
  // just after the falling edge with quiet inputs applied.
  task automatic tick(bit rn, bit st, bit sl, bit ben, bit brel,
                      logic [7:0] breg, bit hl);
    rst_n = rn; start = st; stall = sl; br_en = ben; br_rel = brel;
    br_reg = breg; halt = hl;
    @(posedge clk);
    model_edge(rn, st, sl, ben, brel, breg, hl);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; br_en = 1'b0; br_rel = 1'b0;
    br_reg = 8'h00; halt = 1'b0;
    #1;
  endtask

  task automatic idle_tick();
    tick(1, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic run_to(int target);
    int guard = 0;
    while (m_pc10 != target && guard < 2000) begin
      idle_tick();
      guard++;
    end
    n_checks++;
    if (pc10 !== 10'(target)) begin
      n_fail++; $display("FAIL run_to_pc: got %0d expected %0d", pc10, target);
    end
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (pc10 !== 10'd0 || done10 !== 1'b0 || fv10 !== 1'b0 || cc10 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%0d done=%b fv=%b cc=%0d expected 0/0/0/0",
               pc10, done10, fv10, cc10);
    end
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    run_to(37);
    n_checks++;
    if (fv10 !== 1'b1) begin
      n_fail++; $display("FAIL running_fv: got %b expected 1", fv10);
    end
    // Reset must win over start, branch and halt in the same cycle.
    tick(0, 1, 0, 1, 0, 8'h55, 1);
    n_checks++;
    if (pc10 !== 10'd0 || done10 !== 1'b0 || fv10 !== 1'b0 || cc10 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got pc=%0d done=%b fv=%b cc=%0d expected 0/0/0/0",
               pc10, done10, fv10, cc10);
    end
    idle_tick();
    n_checks++;
    if (pc10 !== 10'd0 || fv10 !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got pc=%0d fv=%b expected 0/0", pc10, fv10);
    end
  endtask

  task automatic test_seq_wrap();
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) begin
      n_checks++;
      if (pc4 !== 4'(i % 16) || fv4 !== 1'b1 || pc10 !== 10'(i)) begin
        n_fail++;
        $display("FAIL seq_wrap[%0d]: got pc4=%0d fv4=%b pc10=%0d expected %0d/1/%0d",
                 i, pc4, fv4, pc10, i % 16, i);
      end
      idle_tick();
    end
  endtask

  task automatic test_branch();
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    run_to(5);
    tick(1, 0, 0, 1, 0, 8'hC8, 0);
    n_checks++;
    if (pc10 !== 10'd200 || pc4 !== 4'(m_pc4)) begin
      n_fail++;
      $display("FAIL abs_branch: got pc10=%0d pc4=%0d expected 200/%0d", pc10, pc4, m_pc4);
    end
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    run_to(3);
    tick(1, 0, 0, 1, 1, 8'hF6, 0);
    n_checks++;
    if (pc10 !== 10'd1017 || pc4 !== 4'(m_pc4)) begin
      n_fail++;
      $display("FAIL rel_branch: got pc10=%0d pc4=%0d expected 1017/%0d", pc10, pc4, m_pc4);
    end
    idle_tick();
    n_checks++;
    if (pc10 !== 10'd1018) begin
      n_fail++; $display("FAIL after_rel_branch: got %0d expected 1018", pc10);
    end
  endtask

  task automatic test_stall_precedence();
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    run_to(12);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; br_en = 1'b1; halt = 1'b1; br_reg = 8'h20;
      #1;
      n_checks++;
      if (fv10 !== 1'b0) begin
        n_fail++; $display("FAIL stall_fv[%0d]: got %b expected 0", i, fv10);
      end
      tick(1, 0, 1, 1, 0, 8'h20, 1);
      n_checks++;
      if (pc10 !== 10'd12 || done10 !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got pc=%0d done=%b expected 12/0", i, pc10, done10);
      end
    end
    tick(1, 0, 0, 1, 0, 8'h20, 1);
    n_checks++;
    if (done10 !== 1'b1 || pc10 !== 10'd12 || fv10 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_taken: got done=%b pc=%0d fv=%b expected 1/12/0", done10, pc10, fv10);
    end
    idle_tick();
    idle_tick();
    n_checks++;
    if (done10 !== 1'b1 || pc10 !== 10'd12) begin
      n_fail++; $display("FAIL done_hold: got done=%b pc=%0d expected 1/12", done10, pc10);
    end
  endtask

  task automatic test_restart();
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (pc10 !== 10'd0 || done10 !== 1'b0 || fv10 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got pc=%0d done=%b fv=%b expected 0/0/1", pc10, done10, fv10);
    end
    run_to(4);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (pc10 !== 10'd5 || done10 !== 1'b0) begin
      n_fail++; $display("FAIL start_in_run: got pc=%0d done=%b expected 5/0", pc10, done10);
    end
  endtask

  task automatic test_cycle_count();
    int want;
`ifdef CYCLE_CNT_EN
    want = 6;
`else
    want = 0;
`endif
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    repeat (3) idle_tick();
    repeat (2) tick(1, 0, 1, 0, 0, 8'h00, 0);
    repeat (2) idle_tick();
    tick(1, 0, 0, 0, 0, 8'h00, 1);
    n_checks++;
    if (cc10 !== 16'(want) || done10 !== 1'b1) begin
      n_fail++;
      $display("FAIL cycle_count: got cc=%0d done=%b expected %0d/1", cc10, done10, want);
    end
    repeat (3) idle_tick();
    n_checks++;
    if (cc10 !== 16'(want)) begin
      n_fail++; $display("FAIL cycle_count_hold: got %0d expected %0d", cc10, want);
    end
    tick(1, 1, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (cc10 !== 16'd0) begin
      n_fail++; $display("FAIL cycle_count_clear: got %0d expected 0", cc10);
    end
  endtask

  task automatic test_random();
    bit rn, st, sl, ben, brel, hl;
    logic [7:0] breg;
    tick(0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 600; i++) begin
      rn   = ($urandom_range(0, 59) != 0);
      st   = ($urandom_range(0, 5) == 0);
      sl   = ($urandom_range(0, 3) == 0);
      ben  = ($urandom_range(0, 4) == 0);
      brel = $urandom_range(0, 1) == 1;
      hl   = ($urandom_range(0, 29) == 0);
      breg = 8'($urandom);
      rst_n = rn; start = st; stall = sl; br_en = ben; br_rel = brel;
      br_reg = breg; halt = hl;
      #1;
      n_checks++;
      if (fv10 !== ((m_mode == M_RUN) && !sl) || fv4 !== fv10) begin
        n_fail++;
        $display("FAIL rand_fv[%0d]: got %b/%b expected %b", i, fv10, fv4,
                 (m_mode == M_RUN) && !sl);
      end
      tick(rn, st, sl, ben, brel, breg, hl);
      n_checks++;
      if (pc10 !== 10'(m_pc10) || pc4 !== 4'(m_pc4) ||
          done10 !== (m_mode == M_DONE) || done4 !== (m_mode == M_DONE) ||
          cc10 !== 16'(exp_cc()) || cc4 !== 16'(exp_cc())) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got pc=%0d/%0d done=%b/%b cc=%0d/%0d expected pc=%0d/%0d done=%b cc=%0d",
                 i, pc10, pc4, done10, done4, cc10, cc4, m_pc10, m_pc4,
                 m_mode == M_DONE, exp_cc());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; br_en = 1'b0; br_rel = 1'b0;
    br_reg = 8'h00; halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_seq_wrap();
    test_branch();
    test_stall_precedence();
    test_restart();
    test_cycle_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
